// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Run/pause/clear controller and timebase for a 4-digit BCD seconds counter.
//   A prescaler divides CLOCK_50 into a one-cycle tick. Each tick advances a
//   4-digit BCD count (0000-9999). An IDLE/RUN/PAUSE/DONE state machine,
//   driven by start/stop/clear pulses, sequences the count. The count stops
//   when it reaches a BCD limit selected on switches.
//
// Ports
//   CLOCK_50  in   1   sole clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   start     in   1   one-cycle start pulse
//   stop      in   1   one-cycle stop pulse
//   clear     in   1   one-cycle clear pulse
//   limit     in   16  BCD stop value {d3,d2,d1,d0}; 16'h0000 = no limit
//   bcd       out  16  registered BCD count {d3,d2,d1,d0}
//   running   out  1   registered, high while in RUN
//   done      out  1   registered, high while in DONE
//   tick      out  1   registered one-cycle pulse on each counted second
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned TICK_W   = 26
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic [15:0] limit,
   output logic [15:0] bcd,
   output logic        running,
   output logic        done,
   output logic        tick
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 32'd1);
   localparam logic [TICK_W-1:0] PRESC_ONE  = TICK_W'(32'd1);
   localparam logic [TICK_W-1:0] PRESC_ZERO = TICK_W'(32'd0);

   // Ripple-carry BCD increment; 9999 wraps to 0000.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
               carry       = 1'b1;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // A limit is usable only when non-zero and every nibble is a decimal
   // digit. Any other value can never be matched by the count.
   function automatic logic limit_ok(input logic [15:0] v);
      logic ok;
      ok = (v != 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] > 4'd9) begin
            ok = 1'b0;
         end else begin
            ok = ok;
         end
      end
      return ok;
   endfunction

   state_t            state_r;
   state_t            state_nx_s;
   logic [TICK_W-1:0] presc_r;
   logic [TICK_W-1:0] presc_nx_s;
   logic [15:0]       bcd_r;
   logic [15:0]       bcd_nx_s;
   logic [15:0]       bcd_inc_s;
   logic              tick_nx_s;
   logic              wrap_s;
   logic              hit_s;

   assign bcd_inc_s = bcd_inc(bcd_r);
   assign wrap_s    = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
   assign hit_s     = wrap_s && limit_ok(limit) && (bcd_inc_s == limit);
   assign bcd       = bcd_r;

   // Next-state, prescaler, count and tick decisions.
   always_comb begin
      state_nx_s = state_r;
      presc_nx_s = presc_r;
      bcd_nx_s   = bcd_r;
      tick_nx_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            presc_nx_s = PRESC_ZERO;
            bcd_nx_s   = 16'h0000;
            // stop outranks start even though it has no effect here
            if (clear || stop) begin
               state_nx_s = ST_IDLE;
            end else if (start) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_nx_s = ST_IDLE;
               presc_nx_s = PRESC_ZERO;
               bcd_nx_s   = 16'h0000;
            end else begin
               // The count still advances on a stop edge; the pause follows.
               if (wrap_s) begin
                  presc_nx_s = PRESC_ZERO;
                  bcd_nx_s   = bcd_inc_s;
                  tick_nx_s  = 1'b1;
               end else begin
                  presc_nx_s = presc_r + PRESC_ONE;
               end
               if (hit_s) begin
                  state_nx_s = ST_DONE;
               end else if (stop) begin
                  state_nx_s = ST_PAUSE;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end
         end
         ST_PAUSE: begin
            // The prescaler holds, so the fractional second survives a pause.
            if (clear) begin
               state_nx_s = ST_IDLE;
               presc_nx_s = PRESC_ZERO;
               bcd_nx_s   = 16'h0000;
            end else if (stop) begin
               state_nx_s = ST_PAUSE;
            end else if (start) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_PAUSE;
            end
         end
         ST_DONE: begin
            if (clear) begin
               state_nx_s = ST_IDLE;
               presc_nx_s = PRESC_ZERO;
               bcd_nx_s   = 16'h0000;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            presc_nx_s = PRESC_ZERO;
            bcd_nx_s   = 16'h0000;
         end
      endcase
   end

   // State, prescaler and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= ST_IDLE;
         presc_r <= PRESC_ZERO;
         bcd_r   <= 16'h0000;
         running <= 1'b0;
         done    <= 1'b0;
         tick    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         presc_r <= presc_nx_s;
         bcd_r   <= bcd_nx_s;
         running <= (state_nx_s == ST_RUN);
         done    <= (state_nx_s == ST_DONE);
         tick    <= tick_nx_s;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl with TICK_DIV=4. Every driven cycle
//   pushes the expected outputs from an integer-seconds reference model onto a
//   scoreboard queue. The entry is popped and compared after the clock edge.
//   Additional directed checks compare outputs against fixed values at the
//   interesting points.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int DIV = 4;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        start    = 1'b0;
   logic        stop     = 1'b0;
   logic        clear    = 1'b0;
   logic [15:0] limit    = 16'h0000;
   logic [15:0] bcd;
   logic        running;
   logic        done;
   logic        tick;

   stopwatch_ctrl #(.TICK_DIV(DIV), .TICK_W(3)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .limit    (limit),
      .bcd      (bcd),
      .running  (running),
      .done     (done),
      .tick     (tick)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: 0 idle, 1 run, 2 pause, 3 done
   int m_state = 0;
   int m_phase = 0;
   int m_secs  = 0;
   bit m_tick  = 1'b0;

   logic [18:0] exp_q[$];

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      r[3:0]   = 4'(n % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[15:12] = 4'((n / 1000) % 10);
      return r;
   endfunction

   function automatic int from_bcd(input logic [15:0] v);
      return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   // a limit with a non-decimal nibble fails the round trip
   function automatic bit lim_ok(input logic [15:0] v);
      return (v != 16'h0000) && (to_bcd(from_bcd(v)) == v);
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_phase = 0;
      m_secs  = 0;
      m_tick  = 1'b0;
   endtask

   task automatic model_edge(input bit s, input bit p, input bit c);
      bit wrap;
      wrap   = (m_state == 1) && (m_phase == DIV - 1);
      m_tick = 1'b0;
      if (c) begin
         m_state = 0;
         m_phase = 0;
         m_secs  = 0;
      end else if (m_state == 0) begin
         if (s && !p) m_state = 1;
      end else if (m_state == 1) begin
         if (wrap) begin
            m_phase = 0;
            m_secs  = (m_secs + 1) % 10000;
            m_tick  = 1'b1;
         end else begin
            m_phase = m_phase + 1;
         end
         if (wrap && lim_ok(limit) && to_bcd(m_secs) == limit) m_state = 3;
         else if (p) m_state = 2;
      end else if (m_state == 2) begin
         if (!p && s) m_state = 1;
      end
   endtask

   // drive one cycle, push the expectation, compare after the edge
   task automatic cyc(input bit s, input bit p, input bit c, input bit r);
      logic [18:0] obs;
      logic [18:0] expv;
      start = s;
      stop  = p;
      clear = c;
      reset = r;
      if (r) model_reset();
      else   model_edge(s, p, c);
      exp_q.push_back({to_bcd(m_secs), m_state == 1, m_state == 3, m_tick});
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      reset = 1'b0;
      obs   = {bcd, running, done, tick};
      expv  = exp_q.pop_front();
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL sb t=%0t bcd/run/done/tick got %h/%b/%b/%b want %h/%b/%b/%b",
                  $time, obs[18:3], obs[2], obs[1], obs[0], expv[18:3], expv[2], expv[1], expv[0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s got %h want %h", tag, obs, expv);
   endtask

   // run until the model has just ticked to the target second (bounded)
   task automatic run_until_secs(input int target);
      for (int i = 0; i < 50000; i++) begin
         if (m_secs == target && m_tick) break;
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      chk("reach", bcd, to_bcd(target));
   endtask

   initial begin
      // reset
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_bcd", bcd, 16'h0000);
      chk("rst_flags", {13'd0, running, done, tick}, 16'h0000);

      // 1: start latency and first ticks
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_running", {15'd0, running}, 16'h0001);
      idle(3);
      chk("t1_notick", {15'd0, tick}, 16'h0000);
      idle(1);
      chk("t1_tick", {15'd0, tick}, 16'h0001);
      chk("t1_bcd1", bcd, 16'h0001);
      idle(8);
      chk("t1_bcd3", bcd, 16'h0003);

      // 2: decimal carries and full wrap
      run_until_secs(99);
      idle(DIV);
      chk("t2_carry", bcd, 16'h0100);
      run_until_secs(9999);
      idle(DIV);
      chk("t2_wrap", bcd, 16'h0000);
      chk("t2_run", {15'd0, running}, 16'h0001);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_clr", bcd, 16'h0000);

      // 3: limit reached, start ignored, clear
      limit = 16'h0012;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_until_secs(12);
      chk("t3_done", {14'd0, running, done}, 16'h0001);
      chk("t3_bcd", bcd, 16'h0012);
      for (int i = 0; i < 20; i++) cyc(1'b1, (i % 3) == 0, 1'b0, 1'b0);
      chk("t3_frozen", bcd, 16'h0012);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_clr", {bcd[15:2], running, done}, 16'h0000);
      // non-decimal limit never matches
      limit = 16'h000C;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_until_secs(13);
      chk("t3_badlim", {15'd0, running}, 16'h0001);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      limit = 16'h0000;

      // 4: pause keeps the fractional second
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_until_secs(2);
      idle(1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_paused", {15'd0, running}, 16'h0000);
      idle(30);
      chk("t4_hold", bcd, 16'h0002);
      chk("t4_notick", {15'd0, tick}, 16'h0000);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("t4_early", {15'd0, tick}, 16'h0000);
      idle(1);
      chk("t4_tick", {15'd0, tick}, 16'h0001);
      chk("t4_bcd", bcd, 16'h0003);

      // 5: same-edge events
      idle(DIV - 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t5_stoptick", {bcd[11:0], 1'b0, running, done, tick}, 16'h0041);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(DIV - 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_clrtick", {bcd[14:0], tick}, 16'h0000);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5_ss_run", {15'd0, running}, 16'h0000);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5_ss_pause", {15'd0, running}, 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      limit = 16'h0002;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_until_secs(1);
      idle(DIV - 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t5_hitstop", {bcd[13:0], running, done}, 16'h0009);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      limit = 16'h0000;

      // 6: reset mid-run
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      run_until_secs(457);
      idle(2);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_bcd", bcd, 16'h0000);
      chk("t6_flags", {13'd0, running, done, tick}, 16'h0000);
      idle(1);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      chk("t6_early", {15'd0, tick}, 16'h0000);
      idle(1);
      chk("t6_tick", {15'd0, tick}, 16'h0001);
      chk("t6_bcd1", bcd, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
